isqrt_seq: RTL

Sequential integer square-root unit: the inverse counterpart of the multi-cycle squarer in the Monte-Carlo estimator datapath. It accepts an unsigned radicand and returns floor(sqrt) one result bit per clock, using the restoring digit-by-digit method. It uses a start/busy/done handshake so a small controller or the scan-chain I/O mux can drive it with a few pins. It sits beside the estimator, for example to derive sqrt(hit count) or to check squarer results.

---
 rtl/isqrt_seq.sv | 123 ++++++++++++
 1 files changed

// File: rtl/isqrt_seq.sv
// Sequential floor(sqrt) unit: restoring digit-by-digit method, one root bit per clock.
// Optional remainder output enabled with macro ISQRT_REM_EN.
module isqrt_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   radicand,
    output logic               busy,
    output logic               done,
    output logic [WIDTH/2-1:0] root
`ifdef ISQRT_REM_EN
    ,
    output logic [WIDTH/2:0]   rem
`endif
);

    localparam int unsigned RW  = WIDTH / 2;
    localparam int unsigned RRW = RW + 2;
    localparam int unsigned XW  = RW + 4;
    localparam int unsigned CW  = (RW > 1) ? $clog2(RW) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [RRW-1:0]   r_q, r_d;
    logic [RW-1:0]    q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [RW-1:0]    root_q, root_d;
`ifdef ISQRT_REM_EN
    logic [RW:0]      rem_q, rem_d;
`endif

    // One restoring iteration; widened so the compare/subtract can never wrap
    logic [XW-1:0]  r_wide, t_wide;
    logic           take;
    logic [RRW-1:0] r_next;
    logic [RW-1:0]  q_next;

    always_comb begin
        r_wide = {r_q, d_q[WIDTH-1:WIDTH-2]};
        t_wide = {2'b00, q_q, 2'b01};
        take   = (r_wide >= t_wide);
        r_next = take ? RRW'(r_wide - t_wide) : RRW'(r_wide);
        q_next = {q_q[RW-2:0], take};
    end

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        r_d     = r_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        root_d  = root_q;
`ifdef ISQRT_REM_EN
        rem_d   = rem_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    d_d     = radicand;
                    r_d     = '0;
                    q_d     = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                d_d   = {d_q[WIDTH-3:0], 2'b00};
                r_d   = r_next;
                q_d   = q_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(RW - 1)) begin
                    state_d = S_DONE;
                    root_d  = q_next;
`ifdef ISQRT_REM_EN
                    rem_d   = r_next[RW:0];
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            d_q     <= '0;
            r_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            root_q  <= '0;
`ifdef ISQRT_REM_EN
            rem_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            r_q     <= r_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            root_q  <= root_d;
`ifdef ISQRT_REM_EN
            rem_q   <= rem_d;
`endif
        end
    end

    // Status decoded straight from the state register, so no input-to-output path
    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign root = root_q;
`ifdef ISQRT_REM_EN
    assign rem  = rem_q;
`endif

endmodule
